// File: rtl/voq_pkt_scheduler_pkg.sv
// Shared types for the per-output-port VOQ packet scheduler: arbitration modes,
// FSM state encoding and mode normalisation.
package voq_pkt_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_MODE_RR  = 2'd0,
    SCHED_MODE_WRR = 2'd1,
    SCHED_MODE_SP  = 2'd2
  } sched_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  // Encoding 3 is reserved and behaves as round-robin.
  function automatic sched_mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return SCHED_MODE_WRR;
      2'd2:    return SCHED_MODE_SP;
      default: return SCHED_MODE_RR;
    endcase
  endfunction

endpackage

// File: rtl/voq_pkt_scheduler_if.sv
// Bundle between a VOQ scheduler, the switch core empty flags and the port's
// read-control logic.
interface voq_pkt_scheduler_if #(
  parameter int N  = 4,
  parameter int WW = 3
);
  import voq_pkt_scheduler_pkg::*;

  localparam int IW = $clog2(N);

  // Handshake: a VOQ offers a packet while its empty_in bit is low. In IDLE a
  // grant fires only when ready_in is high; rd_en then stays high with rd_sel
  // stable until a one-cycle rd_done (or the timeout), followed by a 2-cycle gap.
  logic [N-1:0]    empty_in;
  logic            ready_in;
  logic [1:0]      mode_in;
  logic [N*WW-1:0] wieght_in;
  logic            rd_done;
  logic            rd_en;
  logic [IW-1:0]   rd_sel;
  logic            busy;
  logic            timeout_err;
  sched_state_e    dbg_state;

  modport slave (
    input  empty_in, ready_in, mode_in, wieght_in, rd_done,
    output rd_en, rd_sel, busy, timeout_err, dbg_state
  );

  modport master (
    output empty_in, ready_in, mode_in, wieght_in, rd_done,
    input  rd_en, rd_sel, busy, timeout_err, dbg_state
  );

endinterface

// File: rtl/voq_pkt_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo N.
// Implemented as rotate / find-first / unrotate.
module voq_pkt_scheduler_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             first;
  int             sum;

  always_comb begin
    dbl     = {req, req} >> (int'(ptr) + 1);
    rot     = dbl[N-1:0];
    first   = 0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        first   = k;
        gnt_vld = 1'b1;
      end
    end
    sum     = (int'(ptr) + 1 + first) % N;
    gnt_idx = IW'(sum);
  end

endmodule

// File: rtl/voq_pkt_scheduler.sv
// Per-output-port packet scheduler: RR / WRR / strict-priority choice of the
// next input VOQ, one whole packet per grant, with a grant-to-done timeout.
module voq_pkt_scheduler
  import voq_pkt_scheduler_pkg::*;
#(
  parameter int PORT_NUB_TOTAL = 4,
  parameter int PRIORITY       = 8,
  parameter int TIMEOUT        = 1024
) (
  input logic               clk,
  input logic               rst_n,
  voq_pkt_scheduler_if.slave bus
);

  localparam int N  = PORT_NUB_TOTAL;
  localparam int WW = $clog2(PRIORITY);
  localparam int IW = $clog2(N);
  localparam int CW = WW + 1;
  localparam int TW = $clog2(TIMEOUT);

  sched_state_e  state_q, state_d;
  logic [N-1:0]  req;
  logic [WW-1:0] w [N];
  logic [CW-1:0] credit [N];
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_idx;
  logic          rr_vld;
  logic [IW-1:0] sp_idx;
  logic [IW-1:0] win_idx;
  logic          reload;
  logic [CW-1:0] cur_credit;
  sched_mode_e   mode_n, mode_q;
  logic          wrr_entry;
  logic          grant_wrr;
  logic [TW-1:0] tmo_cnt;
  logic          grant, done_evt, tmo_evt;
  logic          rd_en_q, timeout_err_q;
  logic [IW-1:0] rd_sel_q;

  assign req       = ~bus.empty_in;
  assign mode_n    = norm_mode(bus.mode_in);
  assign wrr_entry = (mode_n == SCHED_MODE_WRR) && (mode_q != SCHED_MODE_WRR);
  // Credits left over from an earlier WRR period do not count on re-entry.
  assign cur_credit = wrr_entry ? '0 : credit[rr_ptr];

  always_comb begin
    for (int i = 0; i < N; i++) w[i] = bus.wieght_in[i*WW +: WW];
  end

  voq_pkt_scheduler_rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin : sp_max
    logic          found;
    logic [WW-1:0] best;
    found  = 1'b0;
    best   = '0;
    sp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (!found || w[i] > best)) begin
        found  = 1'b1;
        best   = w[i];
        sp_idx = IW'(i);
      end
    end
  end

  always_comb begin
    win_idx = rr_idx;
    reload  = 1'b0;
    case (mode_n)
      SCHED_MODE_WRR: begin
        if (req[rr_ptr] && cur_credit != '0) begin
          win_idx = rr_ptr;
        end else begin
          win_idx = rr_idx;
          reload  = rr_vld;
        end
      end
      SCHED_MODE_SP: win_idx = sp_idx;
      default:       win_idx = rr_idx;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req) && bus.ready_in) begin
          grant   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // A done landing on the expiry cycle wins over the timeout.
        if (bus.rd_done) begin
          done_evt = 1'b1;
          state_d  = ST_GAP;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_evt = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q       <= 1'b0;
      rd_sel_q      <= '0;
      timeout_err_q <= 1'b0;
      rr_ptr        <= IW'(N - 1);
      tmo_cnt       <= '0;
      mode_q        <= SCHED_MODE_RR;
      grant_wrr     <= 1'b0;
      for (int i = 0; i < N; i++) credit[i] <= '0;
    end else begin
      timeout_err_q <= tmo_evt;
      if (state_q == ST_READ) tmo_cnt <= tmo_cnt + TW'(1);
      if (grant) begin
        rd_en_q   <= 1'b1;
        rd_sel_q  <= win_idx;
        tmo_cnt   <= '0;
        mode_q    <= mode_n;
        grant_wrr <= (mode_n == SCHED_MODE_WRR);
        if (mode_n != SCHED_MODE_SP) rr_ptr <= win_idx;
        if (mode_n == SCHED_MODE_WRR) begin
          for (int i = 0; i < N; i++) begin
            if (wrr_entry) credit[i] <= '0;
            if (reload && IW'(i) == win_idx) credit[i] <= CW'(w[i]) + CW'(1);
          end
        end
      end
      if (done_evt || tmo_evt) rd_en_q <= 1'b0;
      // Only a completed packet consumes a credit; aborts do not.
      if (done_evt && grant_wrr && credit[rd_sel_q] != '0)
        credit[rd_sel_q] <= credit[rd_sel_q] - CW'(1);
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_sel      = rd_sel_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.dbg_state   = state_q;

endmodule
